mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the core's single memory port between the instruction-fetch master and the load/store master. It arbitrates requests, locks the winner until its read data or write acknowledge returns, and prevents instruction starvation with a bounded counter. It also raises a hold request toward `ctrl` while a data access is outstanding. The block sits between `ifetch`/the load-store path and the unified memory, with one transaction in flight at a time.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `STARVE_MAX`, 4, consecutive data wins tolerated while fetch waits; 1..15
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous reset, active-low
- `if_req_i`  in  1  fetch request; held until `if_gnt_o`
- `if_addr_i`  in  AW  fetch address
- `if_gnt_o`  out  1  fetch address accepted, one-cycle pulse
- `if_rvalid_o`  out  1  fetch data valid, one-cycle pulse
- `if_rdata_o`  out  DW  fetch data
- `ls_req_i`  in  1  data request; held until `ls_gnt_o`
- `ls_we_i`  in  1  1 = store
- `ls_be_i`  in  DW/8  byte enables
- `ls_addr_i`  in  AW  data address
- `ls_wdata_i`  in  DW  store data
- `ls_gnt_o`  out  1  data address accepted
- `ls_rvalid_o`  out  1  load data valid / store done
- `ls_rdata_o`  out  DW  load data
- `mem_req_o`  out  1  memory request
- `mem_we_o`  out  1  memory write
- `mem_be_o`  out  DW/8  memory byte enables
- `mem_addr_o`  out  AW  memory address
- `mem_wdata_o`  out  DW  memory write data
- `mem_gnt_i`  in  1  memory accepted address phase
- `mem_rvalid_i`  in  1  memory response valid (reads and writes)
- `mem_rdata_i`  in  DW  memory read data
- `hold_flag_o`  out  1  stall request to `ctrl`

## Operation
- Registered state: FSM {IDLE, REQ, WAIT}, `owner` (IF/LS), 4-bit `starve_cnt`.
- Arbitration (evaluated in IDLE, and in WAIT on the `mem_rvalid_i` cycle):
  - LS wins over IF.
  - Exception: IF wins when `starve_cnt == STARVE_MAX` and `if_req_i` is high.
  - The winner is latched into `owner`. The next state is REQ if any request is present, otherwise IDLE.
- `starve_cnt` update at each arbitration:
  - +1 (saturating at 15) when LS wins while `if_req_i` is high.
  - Cleared when IF wins.
  - Otherwise unchanged.
- REQ state:
  - `mem_req_o` = 1. `mem_addr_o`, `mem_we_o`, `mem_be_o` and `mem_wdata_o` mux combinationally from the owner's inputs.
  - IF owner drives `we` = 0, `be` = all ones, `wdata` = 0.
  - On `mem_gnt_i`, the owner's `gnt_o` = `mem_gnt_i` in the same cycle; next state is WAIT.
- WAIT state:
  - `mem_req_o` = 0.
  - On `mem_rvalid_i`, the owner's `rvalid_o` = 1 in the same cycle, then re-arbitrate.
- `if_rdata_o` and `ls_rdata_o` both carry `mem_rdata_i` directly. Only the owner's `rvalid_o` qualifies it.
- Outside REQ, `mem_*` outputs are 0.
- `hold_flag_o` = `ls_req_i`, OR (`owner` == LS and state != IDLE), AND NOT `ls_rvalid_o`.
- Protocol violations:
  - `mem_rvalid_i` in IDLE or REQ is ignored.
  - `mem_gnt_i` outside REQ is ignored.
  - Masters must not drop `req` before `gnt`. Behaviour is undefined if they do.

## Timing
- Reset (`rst` low, asynchronous), forced immediately:
  - FSM = IDLE, `owner` = IF, `starve_cnt` = 0.
  - All `gnt`, `rvalid`, `mem_*` and `hold_flag_o` outputs = 0.
- Reset mid-transaction drops the transaction silently. A late `mem_rvalid_i` after reset is ignored.
- Latency:
  - Request seen high at edge N → `mem_req_o` high in cycle N+1.
  - With zero-wait memory: `gnt` in N+1, `rvalid` in N+2.
- Back-to-back: when a request is pending on the `rvalid` cycle, the next REQ starts the following cycle. Sustained throughput is one transaction per 2 cycles.
- Simultaneous requests in the same cycle: LS is served, IF waits, and `starve_cnt` increments.
- A master holding `req` high in the cycle after its `gnt` is treated as a new request.
- `hold_flag_o` is combinational. It falls in the same cycle as `ls_rvalid_o`.

## Test plan
- Single fetch:
  - Stimulus: `if_req_i` = 1, `if_addr_i` = 0x100, memory grants immediately and returns 0x00000013 one cycle later.
  - Required: `mem_addr_o` = 0x100, `mem_we_o` = 0, `if_gnt_o` pulses, `if_rvalid_o` pulses with `if_rdata_o` = 0x00000013, `ls_*` outputs stay 0.
- Simultaneous requests:
  - Stimulus: IF at 0x200 and LS store (addr 0x1000, wdata 0xDEADBEEF, be 0xF) raised in the same cycle.
  - Required: the store is issued first with `hold_flag_o` = 1 until `ls_rvalid_o`. The fetch is issued in the cycle after `ls_rvalid_o`. `starve_cnt` = 1.
- Starvation bound:
  - Stimulus: LS requests continuously, IF requests continuously, `STARVE_MAX` = 4.
  - Required: exactly 4 LS transactions, then 1 IF transaction, then LS resumes. The pattern repeats.
- Wait states:
  - Stimulus: `mem_gnt_i` delayed 3 cycles, `mem_rvalid_i` delayed 5 cycles after `gnt`.
  - Required: `mem_req_o` and the address stay stable through the gnt delay. `rvalid` arrives on the correct master only. `hold_flag_o` stays high throughout for an LS access.
- Reset mid-transaction:
  - Stimulus: `rst` pulsed low while in WAIT for LS, then `mem_rvalid_i` arrives afterwards.
  - Required: all outputs drop to 0 asynchronously, the stale `rvalid` is not forwarded, and the FSM is in IDLE.
- Spurious response:
  - Stimulus: `mem_rvalid_i` = 1 in IDLE.
  - Required: no `rvalid_o` on either master and no state change.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one memory port between the instruction-fetch master (if_*) and the
// load/store master (ls_*). One transaction is in flight at a time. The
// winner owns the port until its read data or write acknowledge comes back.
// Load/store normally wins. Fetch is forced through after STARVE_MAX
// consecutive load/store wins that happened while fetch was waiting.
//
// Ports
//   clk, rst                  clock (rising edge), async reset (active low)
//   if_req_i/if_addr_i        fetch request and address
//   if_gnt_o/if_rvalid_o      fetch address accepted / fetch data valid
//   if_rdata_o                fetch data (qualified by if_rvalid_o)
//   ls_req_i/ls_we_i/ls_be_i  data request, store flag, byte enables
//   ls_addr_i/ls_wdata_i      data address and store data
//   ls_gnt_o/ls_rvalid_o      data address accepted / load data or store done
//   ls_rdata_o                load data (qualified by ls_rvalid_o)
//   mem_*_o                   memory request side
//   mem_gnt_i/mem_rvalid_i    memory address accept / response valid
//   mem_rdata_i               memory read data
//   hold_flag_o               stall request to ctrl while a data access is pending
//
// state | meaning
// IDLE  | no transaction; arbitrate every cycle
// REQ   | address phase for owner; waiting for mem_gnt_i
// WAIT  | address accepted; waiting for mem_rvalid_i, then re-arbitrate
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_i,
  input  logic [AW-1:0]   if_addr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [DW-1:0]   if_rdata_o,
  input  logic            ls_req_i,
  input  logic            ls_we_i,
  input  logic [DW/8-1:0] ls_be_i,
  input  logic [AW-1:0]   ls_addr_i,
  input  logic [DW-1:0]   ls_wdata_i,
  output logic            ls_gnt_o,
  output logic            ls_rvalid_o,
  output logic [DW-1:0]   ls_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [DW/8-1:0] mem_be_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [DW-1:0]   mem_rdata_i,
  output logic            hold_flag_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic       OWN_IF     = 1'b0;
  localparam logic       OWN_LS     = 1'b1;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic [3:0] starve_q, starve_d;

  logic arb_en;
  logic if_urgent;
  logic ls_win;
  logic if_win;
  logic ls_rv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_IF;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if_gnt_o    = 1'b0;
    ls_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    ls_rv       = 1'b0;

    // Arbitration happens when the port is free: in IDLE, or on the response
    // cycle of the current transaction (back-to-back issue).
    arb_en    = (state_q == IDLE) || ((state_q == WAIT) && mem_rvalid_i);
    if_urgent = if_req_i && (starve_q == STARVE_LIM);
    ls_win    = ls_req_i && !if_urgent;
    if_win    = if_req_i && !ls_win;

    case (state_q)
      IDLE, WAIT: begin
        if (state_q == WAIT) begin
          if_rvalid_o = mem_rvalid_i && (owner_q == OWN_IF);
          ls_rv       = mem_rvalid_i && (owner_q == OWN_LS);
        end
        if (arb_en) begin
          if (ls_win) begin
            owner_d = OWN_LS;
            state_d = REQ;
            if (if_req_i && (starve_q != 4'hF)) starve_d = starve_q + 4'd1;
          end else if (if_win) begin
            owner_d  = OWN_IF;
            state_d  = REQ;
            starve_d = 4'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      REQ: begin
        mem_req_o = 1'b1;
        if (owner_q == OWN_LS) begin
          mem_we_o    = ls_we_i;
          mem_be_o    = ls_be_i;
          mem_addr_o  = ls_addr_i;
          mem_wdata_o = ls_wdata_i;
          ls_gnt_o    = mem_gnt_i;
        end else begin
          mem_be_o   = '1;
          mem_addr_o = if_addr_i;
          if_gnt_o   = mem_gnt_i;
        end
        if (mem_gnt_i) state_d = WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ls_rvalid_o = ls_rv;
  assign if_rdata_o  = mem_rdata_i;
  assign ls_rdata_o  = mem_rdata_i;

  // ls_req_i feeds this combinationally, so reset gates it to keep the stall
  // request low while the block is held in reset.
  assign hold_flag_o = rst && (ls_req_i || ((owner_q == OWN_LS) && (state_q != IDLE))) && !ls_rv;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;
  localparam int M_IF = 1;
  localparam int M_LS = 2;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ls_item_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic if_req_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic if_gnt_o, if_rvalid_o;
  logic [DW-1:0] if_rdata_o;
  logic ls_req_i = 1'b0;
  logic ls_we_i = 1'b0;
  logic [DW/8-1:0] ls_be_i = '0;
  logic [AW-1:0] ls_addr_i = '0;
  logic [DW-1:0] ls_wdata_i = '0;
  logic ls_gnt_o, ls_rvalid_o;
  logic [DW-1:0] ls_rdata_o;
  logic mem_req_o, mem_we_o;
  logic [DW/8-1:0] mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic mem_gnt_i = 1'b0;
  logic mem_rvalid_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic hold_flag_o;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i),
    .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .hold_flag_o(hold_flag_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : ((a ^ 32'h5A5A_0000) + 32'd7);
  endfunction

  // master queues and memory responder settings
  logic [31:0] if_q[$];
  ls_item_t    ls_q[$];
  int gnt_dly = 0;
  int rv_dly  = 0;
  logic spur_rv = 1'b0;
  logic spur_gnt = 1'b0;

  // observations taken on the falling edge
  logic cap_mem_req = 1'b0, cap_mem_gnt = 1'b0, cap_mem_rv = 1'b0;
  logic cap_if_gnt = 1'b0, cap_ls_gnt = 1'b0;
  logic [31:0] cap_addr = '0;
  int served[$];
  int if_gnt_cyc = 0, ls_gnt_cyc = 0, if_rv_cyc = 0, ls_rv_cyc = 0;
  int if_rise_cyc = 0, ls_rise_cyc = 0;
  int if_rv_cnt = 0, ls_rv_cnt = 0, ls_gnt_cnt = 0, mem_rv_in_cnt = 0;
  int req_cycles = 0, hold_cnt = 0;
  logic [31:0] last_addr = '0, last_wdata = '0, last_if_rdata = '0, last_ls_rdata = '0;
  logic last_we = 1'b0;

  // masters and memory responder, driven just after the rising edge
  int reqcnt = 0;
  int wcnt = 0;
  bit waiting = 1'b0;
  logic [31:0] cur_addr = '0;

  always @(posedge clk) begin
    cyc++;
    if (cap_if_gnt && if_q.size() > 0) void'(if_q.pop_front());
    if (cap_ls_gnt && ls_q.size() > 0) void'(ls_q.pop_front());
    if (cap_mem_req && cap_mem_gnt) begin
      waiting  = 1'b1;
      wcnt     = 0;
      reqcnt   = 0;
      cur_addr = cap_addr;
    end else if (cap_mem_req) begin
      reqcnt++;
    end else if (waiting) begin
      if (cap_mem_rv) waiting = 1'b0;
      else wcnt++;
    end
    if (!rst) reqcnt = 0;
    #1;
    if (if_q.size() > 0 && !if_req_i) if_rise_cyc = cyc;
    if (ls_q.size() > 0 && !ls_req_i) ls_rise_cyc = cyc;
    if_req_i   = (if_q.size() > 0);
    if_addr_i  = (if_q.size() > 0) ? if_q[0] : 32'h0;
    ls_req_i   = (ls_q.size() > 0);
    ls_we_i    = (ls_q.size() > 0) ? ls_q[0].we : 1'b0;
    ls_be_i    = (ls_q.size() > 0) ? ls_q[0].be : 4'h0;
    ls_addr_i  = (ls_q.size() > 0) ? ls_q[0].addr : 32'h0;
    ls_wdata_i = (ls_q.size() > 0) ? ls_q[0].wdata : 32'h0;
    mem_gnt_i    = (mem_req_o && (reqcnt >= gnt_dly)) || spur_gnt;
    mem_rvalid_i = (waiting && (wcnt >= rv_dly)) || spur_rv;
    mem_rdata_i  = (waiting && (wcnt >= rv_dly)) ? mem_word(cur_addr)
                 : (spur_rv ? 32'hBAD0_BAD0 : 32'h0);
  end

  // Behavioural model: which master holds the port (0 none), whether its
  // address has been accepted, and how many data wins fetch has sat through.
  int m_busy = 0;
  bit m_done = 1'b0;
  int m_starve = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0;
      m_done = 1'b0;
      m_starve = 0;
    end else if (m_busy != 0 && !m_done) begin
      if (mem_gnt_i) m_done = 1'b1;
    end else if (m_busy == 0 || mem_rvalid_i) begin
      if (ls_req_i && !(if_req_i && m_starve == SMAX)) begin
        if (if_req_i) m_starve = (m_starve >= 15) ? 15 : m_starve + 1;
        m_busy = M_LS;
      end else if (if_req_i) begin
        m_starve = 0;
        m_busy = M_IF;
      end else begin
        m_busy = 0;
      end
      m_done = 1'b0;
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    logic e_req, e_ls_rv;
    logic [31:0] e_addr, e_wdata;
    logic e_we;
    logic [3:0] e_be;
    e_req   = rst && (m_busy != 0) && !m_done;
    e_ls_rv = rst && (m_busy == M_LS) && m_done && mem_rvalid_i;
    e_addr  = 32'h0; e_wdata = 32'h0; e_we = 1'b0; e_be = 4'h0;
    if (e_req && m_busy == M_LS) begin
      e_addr = ls_addr_i; e_wdata = ls_wdata_i; e_we = ls_we_i; e_be = ls_be_i;
    end else if (e_req) begin
      e_addr = if_addr_i; e_be = 4'hF;
    end
    chk("mem_req", 32'(mem_req_o), 32'(e_req));
    chk("mem_addr", mem_addr_o, e_addr);
    chk("mem_we", 32'(mem_we_o), 32'(e_we));
    chk("mem_be", 32'(mem_be_o), 32'(e_be));
    chk("mem_wdata", mem_wdata_o, e_wdata);
    chk("if_gnt", 32'(if_gnt_o), 32'(e_req && m_busy == M_IF && mem_gnt_i));
    chk("ls_gnt", 32'(ls_gnt_o), 32'(e_req && m_busy == M_LS && mem_gnt_i));
    chk("if_rvalid", 32'(if_rvalid_o), 32'(rst && m_busy == M_IF && m_done && mem_rvalid_i));
    chk("ls_rvalid", 32'(ls_rvalid_o), 32'(e_ls_rv));
    chk("hold_flag", 32'(hold_flag_o), 32'(rst && (ls_req_i || m_busy == M_LS) && !e_ls_rv));
    chk("if_rdata", if_rdata_o, mem_rdata_i);
    chk("ls_rdata", ls_rdata_o, mem_rdata_i);

    if (if_gnt_o) begin served.push_back(M_IF); if_gnt_cyc = cyc; end
    if (ls_gnt_o) begin served.push_back(M_LS); ls_gnt_cyc = cyc; ls_gnt_cnt++; end
    if (if_rvalid_o) begin if_rv_cyc = cyc; if_rv_cnt++; last_if_rdata = if_rdata_o; end
    if (ls_rvalid_o) begin ls_rv_cyc = cyc; ls_rv_cnt++; last_ls_rdata = ls_rdata_o; end
    if (mem_req_o) begin
      req_cycles++;
      last_addr = mem_addr_o; last_we = mem_we_o; last_wdata = mem_wdata_o;
    end
    if (hold_flag_o) hold_cnt++;
    if (mem_rvalid_i) mem_rv_in_cnt++;
    cap_mem_req = mem_req_o; cap_mem_gnt = mem_gnt_i; cap_mem_rv = mem_rvalid_i;
    cap_if_gnt = if_gnt_o; cap_ls_gnt = ls_gnt_o; cap_addr = mem_addr_o;
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((if_q.size() > 0 || ls_q.size() > 0 || m_busy != 0) && n < maxc) begin
      tick();
      n++;
    end
    checks++;
    if (n >= maxc) begin
      errors++;
      $display("FAIL idle_timeout at cycle %0d: still busy after %0d cycles", cyc, n);
    end
    tick();
    tick();
  endtask

  int exp_pat[14] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1, 2, 2, 2, 2};

  initial begin
    int n, base, rv_before;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req_o), 32'h0);
    chk("rst_hold", 32'(hold_flag_o), 32'h0);
    chk("rst_if_gnt", 32'(if_gnt_o), 32'h0);
    chk("rst_ls_rvalid", 32'(ls_rvalid_o), 32'h0);
    #2 rst = 1'b1;
    tick();

    // single fetch
    served.delete();
    if_q.push_back(32'h100);
    wait_idle(50);
    chk("fetch_count", 32'(served.size()), 32'd1);
    chk("fetch_owner", 32'((served.size() > 0) ? served[0] : 0), 32'(M_IF));
    chk("fetch_addr", last_addr, 32'h100);
    chk("fetch_we", 32'(last_we), 32'h0);
    chk("fetch_gnt_lat", 32'(if_gnt_cyc - if_rise_cyc), 32'd1);
    chk("fetch_rv_lat", 32'(if_rv_cyc - if_rise_cyc), 32'd2);
    chk("fetch_rdata", last_if_rdata, 32'h0000_0013);
    chk("fetch_no_ls_rv", 32'(ls_rv_cnt), 32'd0);

    // simultaneous store and fetch
    served.delete();
    hold_cnt = 0;
    if_q.push_back(32'h200);
    ls_q.push_back('{we: 1'b1, be: 4'hF, addr: 32'h1000, wdata: 32'hDEADBEEF});
    wait_idle(50);
    chk("simul_count", 32'(served.size()), 32'd2);
    chk("simul_first", 32'((served.size() > 0) ? served[0] : 0), 32'(M_LS));
    chk("simul_second", 32'((served.size() > 1) ? served[1] : 0), 32'(M_IF));
    chk("simul_if_after_ls", 32'(if_gnt_cyc - ls_rv_cyc), 32'd1);
    chk("simul_hold_cycles", 32'(hold_cnt), 32'd2);

    // starvation bound
    served.delete();
    for (int i = 0; i < 12; i++)
      ls_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h3000 + 32'(4 * i), wdata: 32'h0});
    for (int i = 0; i < 2; i++) if_q.push_back(32'h400 + 32'(4 * i));
    wait_idle(200);
    chk("starve_count", 32'(served.size()), 32'd14);
    for (int i = 0; i < 14; i++)
      chk($sformatf("starve_order_%0d", i), 32'((served.size() > i) ? served[i] : 0), 32'(exp_pat[i]));

    // wait states
    gnt_dly = 3;
    rv_dly = 5;
    req_cycles = 0;
    hold_cnt = 0;
    rv_before = if_rv_cnt;
    ls_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h2000, wdata: 32'h0});
    wait_idle(100);
    chk("ws_req_cycles", 32'(req_cycles), 32'd4);
    chk("ws_ls_gap", 32'(ls_rv_cyc - ls_gnt_cyc), 32'd6);
    chk("ws_hold_cycles", 32'(hold_cnt), 32'd10);
    chk("ws_ls_rdata", last_ls_rdata, mem_word(32'h2000));
    chk("ws_no_if_rv", 32'(if_rv_cnt), 32'(rv_before));
    rv_before = ls_rv_cnt;
    hold_cnt = 0;
    if_q.push_back(32'h180);
    wait_idle(100);
    chk("ws_if_gap", 32'(if_rv_cyc - if_gnt_cyc), 32'd6);
    chk("ws_if_rdata", last_if_rdata, mem_word(32'h180));
    chk("ws_no_ls_rv", 32'(ls_rv_cnt), 32'(rv_before));
    chk("ws_if_hold", 32'(hold_cnt), 32'd0);
    gnt_dly = 0;

    // reset while a store waits for its response
    rv_dly = 8;
    base = ls_gnt_cnt;
    ls_q.push_back('{we: 1'b1, be: 4'h3, addr: 32'h1800, wdata: 32'h1234_5678});
    n = 0;
    while (ls_gnt_cnt == base && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL rst_mid_gnt_timeout at cycle %0d: no grant within %0d cycles", cyc, n);
    end
    ls_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h1804, wdata: 32'h0});
    tick();
    chk("pre_rst_hold", 32'(hold_flag_o), 32'h1);
    rv_before = ls_rv_cnt;
    base = mem_rv_in_cnt;
    rst = 1'b0;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req_o), 32'h0);
    chk("rst_mid_hold", 32'(hold_flag_o), 32'h0);
    chk("rst_mid_ls_gnt", 32'(ls_gnt_o), 32'h0);
    chk("rst_mid_ls_rv", 32'(ls_rvalid_o), 32'h0);
    chk("rst_mid_mem_addr", mem_addr_o, 32'h0);
    ls_q.delete();
    if_q.delete();
    tick();
    tick();
    rst = 1'b1;
    repeat (12) tick();
    chk("stale_rv_seen", 32'(mem_rv_in_cnt - base), 32'd1);
    chk("stale_rv_dropped", 32'(ls_rv_cnt), 32'(rv_before));
    rv_dly = 0;
    if_q.push_back(32'h104);
    wait_idle(50);
    chk("post_rst_gnt_lat", 32'(if_gnt_cyc - if_rise_cyc), 32'd1);

    // spurious response and grant in IDLE
    rv_before = if_rv_cnt + ls_rv_cnt;
    spur_rv = 1'b1;
    spur_gnt = 1'b1;
    tick();
    spur_rv = 1'b0;
    spur_gnt = 1'b0;
    tick();
    tick();
    chk("spur_no_rvalid", 32'(if_rv_cnt + ls_rv_cnt), 32'(rv_before));
    if_q.push_back(32'h108);
    wait_idle(50);
    chk("spur_gnt_lat", 32'(if_gnt_cyc - if_rise_cyc), 32'd1);
    chk("spur_rdata", last_if_rdata, mem_word(32'h108));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
